// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command encodings, init FSM states and default mode word.
// The SDRAM controller imports the same package.
package sdram_pkg;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP       = 4'b0111;
  localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
  localparam logic [3:0] CMD_REFRESH   = 4'b0001;
  localparam logic [3:0] CMD_LOAD_MODE = 4'b0000;
  localparam logic [3:0] CMD_DESELECT  = 4'b1111;

  // CAS latency 3, sequential, burst length 4
  localparam logic [11:0] MODE_REG_DEFAULT = 12'h032;

  // A10 set selects all banks on PRECHARGE
  localparam logic [11:0] ADDR_PRECHARGE_ALL = 12'h400;

  typedef enum logic [3:0] {
    ST_WAIT_LOCK = 4'd0,
    ST_POWERUP   = 4'd1,
    ST_PRECHARGE = 4'd2,
    ST_WAIT_RP   = 4'd3,
    ST_REFRESH1  = 4'd4,
    ST_WAIT_RFC1 = 4'd5,
    ST_REFRESH2  = 4'd6,
    ST_WAIT_RFC2 = 4'd7,
    ST_LOAD_MODE = 4'd8,
    ST_WAIT_MRD  = 4'd9,
    ST_DONE      = 4'd10
  } init_state_t;

  function automatic logic [15:0] cnt_dec(input logic [15:0] cnt);
    cnt_dec = (cnt != 16'd0) ? (cnt - 16'd1) : 16'd0;
  endfunction

endpackage

// File: rtl/sdram_init_seq_if.sv
// SDRAM command bus plus init_done, driven by the init sequencer.
interface sdram_init_seq_if;
  logic        init_done;
  logic        cke;
  logic        cs_n;
  logic        ras_n;
  logic        cas_n;
  logic        we_n;
  logic [11:0] addr;
  logic [1:0]  ba;

  modport master (
    output init_done, cke, cs_n, ras_n, cas_n, we_n, addr, ba
  );

  modport slave (
    input init_done, cke, cs_n, ras_n, cas_n, we_n, addr, ba
  );
endinterface

// File: rtl/sdram_sync2.sv
// Two-flop synchronizer for a single asynchronous level into the clk domain.
module sdram_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;

  // shift the raw level one stage per clock
  always_comb begin
    sync_d = {sync_q[0], d};
  end

  // synchronizer flops, cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[1];

endmodule

// File: rtl/sdram_init_seq.sv
// SDR-SDRAM power-up sequencer: waits for PLL lock, then NOP delay, PRECHARGE ALL,
// two AUTO REFRESH, LOAD MODE REGISTER, and finally raises init_done.
module sdram_init_seq
  import sdram_pkg::*;
#(
  parameter int unsigned  POWERUP_CYCLES = 20000,
  parameter int unsigned  T_RP           = 2,
  parameter int unsigned  T_RFC          = 7,
  parameter int unsigned  T_MRD          = 2,
  parameter logic [11:0]  MODE_REG       = MODE_REG_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pll_locked,
  sdram_init_seq_if.master  bus
);

  // Wait-state reload values; the issuing state itself accounts for one cycle
  // and the cnt==0 cycle for another, hence the -2.
  localparam logic [15:0] CNT_POWERUP = 16'(POWERUP_CYCLES - 32'd1);
  localparam logic [15:0] CNT_RP      = 16'(T_RP - 32'd2);
  localparam logic [15:0] CNT_RFC     = 16'(T_RFC - 32'd2);
  localparam logic [15:0] CNT_MRD     = 16'(T_MRD - 32'd2);

  logic        lock_s;
  init_state_t state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  cmd_q, cmd_d;
  logic        cke_q, cke_d;
  logic [11:0] addr_q, addr_d;
  logic [1:0]  ba_q, ba_d;
  logic        done_q, done_d;

  sdram_sync2 u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_locked),
    .q   (lock_s)
  );

  // next state and the output values that go with it
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cmd_d   = CMD_NOP;
    cke_d   = 1'b1;
    addr_d  = 12'h000;
    ba_d    = 2'b00;
    done_d  = 1'b0;
    if ((state_q != ST_WAIT_LOCK) && !lock_s) begin
      state_d = ST_WAIT_LOCK;
      cnt_d   = 16'd0;
      cmd_d   = CMD_DESELECT;
      cke_d   = 1'b0;
    end else begin
      case (state_q)
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            state_d = ST_POWERUP;
            cnt_d   = CNT_POWERUP;
          end else begin
            cmd_d = CMD_DESELECT;
            cke_d = 1'b0;
          end
        end
        ST_POWERUP: begin
          if (cnt_q == 16'd0) begin
            state_d = ST_PRECHARGE;
            cmd_d   = CMD_PRECHARGE;
            addr_d  = ADDR_PRECHARGE_ALL;
          end else begin
            cnt_d = cnt_dec(cnt_q);
          end
        end
        ST_PRECHARGE: begin
          state_d = ST_WAIT_RP;
          cnt_d   = CNT_RP;
        end
        ST_WAIT_RP: begin
          if (cnt_q == 16'd0) begin
            state_d = ST_REFRESH1;
            cmd_d   = CMD_REFRESH;
          end else begin
            cnt_d = cnt_dec(cnt_q);
          end
        end
        ST_REFRESH1: begin
          state_d = ST_WAIT_RFC1;
          cnt_d   = CNT_RFC;
        end
        ST_WAIT_RFC1: begin
          if (cnt_q == 16'd0) begin
            state_d = ST_REFRESH2;
            cmd_d   = CMD_REFRESH;
          end else begin
            cnt_d = cnt_dec(cnt_q);
          end
        end
        ST_REFRESH2: begin
          state_d = ST_WAIT_RFC2;
          cnt_d   = CNT_RFC;
        end
        ST_WAIT_RFC2: begin
          if (cnt_q == 16'd0) begin
            state_d = ST_LOAD_MODE;
            cmd_d   = CMD_LOAD_MODE;
            addr_d  = MODE_REG;
          end else begin
            cnt_d = cnt_dec(cnt_q);
          end
        end
        ST_LOAD_MODE: begin
          state_d = ST_WAIT_MRD;
          cnt_d   = CNT_MRD;
        end
        ST_WAIT_MRD: begin
          if (cnt_q == 16'd0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_dec(cnt_q);
          end
        end
        ST_DONE: begin
          done_d = 1'b1;
        end
        default: begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = 16'd0;
          cmd_d   = CMD_DESELECT;
          cke_d   = 1'b0;
        end
      endcase
    end
  end

  // FSM, counter and registered command-bus outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_WAIT_LOCK;
      cnt_q   <= 16'd0;
      cmd_q   <= CMD_DESELECT;
      cke_q   <= 1'b0;
      addr_q  <= 12'h000;
      ba_q    <= 2'b00;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      cke_q   <= cke_d;
      addr_q  <= addr_d;
      ba_q    <= ba_d;
      done_q  <= done_d;
    end
  end

  assign bus.init_done = done_q;
  assign bus.cke       = cke_q;
  assign bus.cs_n      = cmd_q[3];
  assign bus.ras_n     = cmd_q[2];
  assign bus.cas_n     = cmd_q[1];
  assign bus.we_n      = cmd_q[0];
  assign bus.addr      = addr_q;
  assign bus.ba        = ba_q;

endmodule
